// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: stalls the pipeline, walks the register file debug port and streams
// every register as bytes to the UART TX. Define REGFILE_DUMP_CHECKSUM_EN for a trailing XOR byte.
module regfile_dump_ctrl #(
    parameter int NUM_REGS      = 32,
    parameter int DRAIN_CYCLES  = 4,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        dbg_on,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        stop_cpu,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [4:0]     LAST_IDX   = 5'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, DRAIN, ADDR, CAPT, SEND, NEXT, FIN, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, DRAIN, ADDR, CAPT, SEND, NEXT, FIN} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   drain_cnt;
    logic [4:0]      idx;
    logic [1:0]      byte_cnt;
    logic [31:0]     cap;
    logic [1:0]      byte_sel;
    logic [7:0]      cap_byte;
    logic            xfer;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    // Big-endian order walks byte lanes 3..0, i.e. the inverted counter.
    assign byte_sel = (LITTLE_ENDIAN != 0) ? byte_cnt : ~byte_cnt;
    assign cap_byte = cap[{byte_sel, 3'b000} +: 8];
    assign dbg_addr = idx;
    assign xfer     = tx_valid & tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dbg_on    = 1'b0;
        stop_cpu  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = cap_byte;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRAIN;
            end
            DRAIN: begin
                stop_cpu = 1'b1;
                busy     = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nxt = ADDR;
            end
            ADDR: begin
                dbg_on    = 1'b1;
                stop_cpu  = 1'b1;
                busy      = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                dbg_on    = 1'b1;
                stop_cpu  = 1'b1;
                busy      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                dbg_on   = 1'b1;
                stop_cpu = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready && byte_cnt == 2'd3) state_nxt = NEXT;
            end
            NEXT: begin
                dbg_on   = 1'b1;
                stop_cpu = 1'b1;
                busy     = 1'b1;
                if (idx == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = FIN;
`endif
                end else begin
                    state_nxt = ADDR;
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM: begin
                dbg_on   = 1'b1;
                stop_cpu = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_nxt = FIN;
            end
`endif
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a start seen in IDLE.
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
            idx       <= '0;
            byte_cnt  <= '0;
            cap       <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (abort) begin
            drain_cnt <= '0;
            byte_cnt  <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        drain_cnt <= '0;
                        idx       <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + DW'(1);
                CAPT: begin
                    cap      <= dbg_data;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum     <= csum ^ cap_byte;
`endif
                    end
                end
                NEXT: begin
                    if (idx != LAST_IDX) idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
